// File: rtl/serial_operand_feeder_if.sv
// Handshake and serial-bit bus between the operand feeder and the bit-serial adder.
// SERIAL_OPERAND_SUB_EN adds the sub request line sampled with the operands.
interface serial_operand_feeder_if #(
  parameter int WIDTH = 8
);
  logic             in_valid;
  logic             in_ready;
  logic [WIDTH-1:0] op_a;
  logic [WIDTH-1:0] op_b;
`ifdef SERIAL_OPERAND_SUB_EN
  logic             sub;
`endif
  logic             stall;
  logic             add_clr;
  logic             add_en;
  logic             a_bit;
  logic             b_bit;
  logic             last;
  logic             busy;

  modport master (
`ifdef SERIAL_OPERAND_SUB_EN
    output sub,
`endif
    output in_valid, op_a, op_b, stall,
    input  in_ready, add_clr, add_en, a_bit, b_bit, last, busy
  );

  modport slave (
`ifdef SERIAL_OPERAND_SUB_EN
    input  sub,
`endif
    input  in_valid, op_a, op_b, stall,
    output in_ready, add_clr, add_en, a_bit, b_bit, last, busy
  );
endinterface

// File: rtl/serial_operand_feeder.sv
// Loads two WIDTH-bit operands, pulses the adder carry clear, then shifts them out LSB-first.
// Optional macro SERIAL_OPERAND_SUB_EN: sub=1 loads the two's-complement negation of op_b.
module serial_operand_feeder #(
  parameter int WIDTH = 8
) (
  input  logic                   clk,
  input  logic                   reset,
  serial_operand_feeder_if.slave bus
);
  localparam int CNT_W = (WIDTH > 2) ? $clog2(WIDTH) : 1;
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(WIDTH - 1);

  typedef enum logic [1:0] {IDLE, CLEAR, SHIFT} state_t;

  state_t                  state, state_nxt;
  logic [WIDTH-1:0]        sa, sb;
  logic [CNT_W-1:0]        cnt;
  logic                    load, shift;
  logic signed [WIDTH-1:0] b_load;
  logic                    run;

`ifdef SERIAL_OPERAND_SUB_EN
  // Most-negative value negates to itself; overflow is flagged downstream.
  function automatic logic signed [WIDTH-1:0] negate(input logic signed [WIDTH-1:0] v);
    return ~v + WIDTH'(1);
  endfunction

  assign b_load = bus.sub ? negate(bus.op_b) : bus.op_b;
`else
  assign b_load = bus.op_b;
`endif

  assign run = ~reset;

  always_ff @(posedge clk) begin
    if (reset) begin
      state <= IDLE;
      sa    <= '0;
      sb    <= '0;
      cnt   <= '0;
    end else begin
      state <= state_nxt;
      if (load) begin
        sa  <= bus.op_a;
        sb  <= b_load;
        cnt <= '0;
      end else if (shift) begin
        sa  <= {1'b0, sa[WIDTH-1:1]};
        sb  <= {1'b0, sb[WIDTH-1:1]};
        cnt <= (cnt == CNT_LAST) ? '0 : cnt + CNT_W'(1);
      end
    end
  end

  // Outputs are forced low while reset is held so an aborted word emits nothing.
  always_comb begin
    state_nxt    = state;
    load         = 1'b0;
    shift        = 1'b0;
    bus.in_ready = 1'b0;
    bus.add_clr  = 1'b0;
    bus.add_en   = 1'b0;
    bus.a_bit    = 1'b0;
    bus.b_bit    = 1'b0;
    bus.last     = 1'b0;
    bus.busy     = 1'b0;
    case (state)
      IDLE: begin
        bus.in_ready = run;
        if (bus.in_valid && run) begin
          load      = 1'b1;
          state_nxt = CLEAR;
        end
      end
      CLEAR: begin
        bus.add_clr = run;
        bus.busy    = run;
        state_nxt   = SHIFT;
      end
      SHIFT: begin
        bus.busy   = run;
        bus.a_bit  = sa[0] & run;
        bus.b_bit  = sb[0] & run;
        bus.last   = (cnt == CNT_LAST) & run;
        bus.add_en = ~bus.stall & run;
        if (!bus.stall) begin
          shift = 1'b1;
          if (cnt == CNT_LAST) state_nxt = IDLE;
        end
      end
      default: state_nxt = IDLE;
    endcase
  end
endmodule

// File: tb/tb_serial_operand_feeder.sv
// Bench for serial_operand_feeder: vector table, directed corner sequences and random words.
module tb_serial_operand_feeder;
  localparam int W = 8;

  logic clk;
  logic reset;
  int   checks = 0;
  int   errors = 0;
  string ctx = "";

  serial_operand_feeder_if #(.WIDTH(W)) bus ();

  serial_operand_feeder #(.WIDTH(W)) dut (
    .clk  (clk),
    .reset(reset),
    .bus  (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #500000;
    $display("FAIL global_timeout");
    $fatal(1, "simulation did not finish");
  end

  typedef struct {
    logic [W-1:0] a;
    logic [W-1:0] b;
    bit           sub;
    logic [31:0]  mask;
    logic [W-1:0] exp_b;
    logic [W-1:0] exp_sum;
    int           exp_cycles;
  } vec_t;

  vec_t tbl[$];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s got %0h want %0h (%s)", name, act, exp, ctx);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Presents one word, then checks the clear pulse and every serial bit against the operands.
  task automatic send_word(input logic [W-1:0] a, input logic [W-1:0] b, input bit sub,
                           input logic [31:0] mask, input bit use_rand,
                           input logic [W-1:0] exp_b, input logic [W-1:0] exp_sum,
                           input int exp_cycles);
    int guard;
    int k;
    int n;
    logic [W-1:0] ga;
    logic [W-1:0] gb;
    $sformat(ctx, "a=%h b=%h sub=%0d", a, b, sub);
    guard = 0;
    bus.in_valid = 1'b1;
    bus.op_a = a;
    bus.op_b = b;
`ifdef SERIAL_OPERAND_SUB_EN
    bus.sub = sub;
`endif
    bus.stall = 1'($urandom_range(0, 1));
    @(negedge clk);
    while (!bus.in_ready && guard < 50) begin
      tick();
      @(negedge clk);
      guard++;
    end
    chk("accept_ready", 32'(bus.in_ready), 1);
    if (!bus.in_ready) begin
      bus.in_valid = 1'b0;
      return;
    end
    tick();
    bus.in_valid = 1'b0;
    bus.op_a = W'($urandom);
    bus.op_b = W'($urandom);
`ifdef SERIAL_OPERAND_SUB_EN
    bus.sub = 1'($urandom_range(0, 1));
`endif
    bus.stall = 1'($urandom_range(0, 1));
    @(negedge clk);
    chk("clr_pulse", 32'(bus.add_clr), 1);
    chk("clr_en", 32'(bus.add_en), 0);
    chk("clr_ready", 32'(bus.in_ready), 0);
    chk("clr_busy", 32'(bus.busy), 1);
    tick();
    k = 0;
    n = 0;
    ga = '0;
    gb = '0;
    while (k < W && n < 3 * W + 20) begin
      if (use_rand) bus.stall = ($urandom_range(0, 3) == 0);
      else          bus.stall = (n < 32) ? mask[n] : 1'b0;
      @(negedge clk);
      chk("a_bit", 32'(bus.a_bit), 32'(a[k]));
      chk("b_bit", 32'(bus.b_bit), 32'(exp_b[k]));
      chk("last", 32'(bus.last), 32'(k == W - 1));
      chk("add_en", 32'(bus.add_en), 32'(!bus.stall));
      chk("shift_clr", 32'(bus.add_clr), 0);
      chk("shift_ready", 32'(bus.in_ready), 0);
      if (!bus.stall) begin
        ga[k] = bus.a_bit;
        gb[k] = bus.b_bit;
        k++;
      end
      n++;
      tick();
    end
    bus.stall = 1'b0;
    chk("bits_done", k, W);
    if (exp_cycles >= 0) chk("shift_cycles", n, exp_cycles);
    chk("sum", 32'(W'(ga + gb)), 32'(exp_sum));
    @(negedge clk);
    chk("end_ready", 32'(bus.in_ready), 1);
    chk("end_busy", 32'(bus.busy), 0);
    chk("end_en", 32'(bus.add_en), 0);
    tick();
  endtask

  initial begin
    logic [W-1:0] ra, rb, reb;
    bit rsub;
    int acc[$];
    logic abits[$];
    logic bbits[$];
    logic [W-1:0] w;

    tbl.push_back(vec_t'{8'h05, 8'h03, 1'b0, 32'h0,  8'h03, 8'h08, 8});
    tbl.push_back(vec_t'{8'h05, 8'h03, 1'b0, 32'h84, 8'h03, 8'h08, 10});
    tbl.push_back(vec_t'{8'h7F, 8'h01, 1'b0, 32'h0,  8'h01, 8'h80, 8});
    tbl.push_back(vec_t'{8'h80, 8'hFF, 1'b0, 32'h01, 8'hFF, 8'h7F, 9});
    tbl.push_back(vec_t'{8'hFF, 8'h80, 1'b0, 32'hFF, 8'h80, 8'h7F, 16});
`ifdef SERIAL_OPERAND_SUB_EN
    tbl.push_back(vec_t'{8'h05, 8'h03, 1'b1, 32'h0,  8'hFD, 8'h02, 8});
    tbl.push_back(vec_t'{8'h05, 8'h80, 1'b1, 32'h0,  8'h80, 8'h85, 8});
    tbl.push_back(vec_t'{8'h05, 8'h03, 1'b0, 32'h0,  8'h03, 8'h08, 8});
`endif

    reset = 1'b1;
    bus.in_valid = 1'b1;
    bus.op_a = 8'h11;
    bus.op_b = 8'h22;
    bus.stall = 1'b0;
`ifdef SERIAL_OPERAND_SUB_EN
    bus.sub = 1'b0;
`endif
    ctx = "reset";
    @(negedge clk);
    chk("rst_ready", 32'(bus.in_ready), 0);
    chk("rst_en", 32'(bus.add_en), 0);
    tick();
    @(negedge clk);
    chk("rst_ready2", 32'(bus.in_ready), 0);
    tick();
    reset = 1'b0;
    bus.in_valid = 1'b0;
    @(negedge clk);
    chk("post_rst_ready", 32'(bus.in_ready), 1);
    chk("post_rst_busy", 32'(bus.busy), 0);
    chk("post_rst_clr", 32'(bus.add_clr), 0);
    chk("post_rst_en", 32'(bus.add_en), 0);
    chk("post_rst_last", 32'(bus.last), 0);
    chk("post_rst_abit", 32'(bus.a_bit), 0);
    chk("post_rst_bbit", 32'(bus.b_bit), 0);
    tick();

    for (int i = 0; i < tbl.size(); i++)
      send_word(tbl[i].a, tbl[i].b, tbl[i].sub, tbl[i].mask, 1'b0,
                tbl[i].exp_b, tbl[i].exp_sum, tbl[i].exp_cycles);

    // Back-to-back words with garbage on the operands while busy.
    ctx = "back_to_back";
    bus.in_valid = 1'b1;
    bus.op_a = 8'h7F;
    bus.op_b = 8'h01;
    bus.stall = 1'b0;
    for (int c = 0; c < 30; c++) begin
      @(negedge clk);
      if (bus.in_ready && bus.in_valid) acc.push_back(c);
      if (bus.add_en) begin
        abits.push_back(bus.a_bit);
        bbits.push_back(bus.b_bit);
      end
      tick();
      if (bus.in_ready) begin
        if (acc.size() == 0) begin
          bus.op_a = 8'h7F;
          bus.op_b = 8'h01;
        end else if (acc.size() == 1) begin
          bus.op_a = 8'h80;
          bus.op_b = 8'hFF;
        end else begin
          bus.in_valid = 1'b0;
        end
      end else begin
        bus.op_a = W'($urandom);
        bus.op_b = W'($urandom);
      end
    end
    bus.in_valid = 1'b0;
    chk("b2b_accepts", acc.size(), 2);
    if (acc.size() >= 2) chk("b2b_spacing", acc[1] - acc[0], W + 2);
    chk("b2b_bits", abits.size(), 2 * W);
    if (abits.size() == 2 * W) begin
      for (int j = 0; j < W; j++) w[j] = abits[j];
      chk("b2b_word0_a", 32'(w), 32'h7F);
      for (int j = 0; j < W; j++) w[j] = bbits[j];
      chk("b2b_word0_b", 32'(w), 32'h01);
      for (int j = 0; j < W; j++) w[j] = abits[W + j];
      chk("b2b_word1_a", 32'(w), 32'h80);
      for (int j = 0; j < W; j++) w[j] = bbits[W + j];
      chk("b2b_word1_b", 32'(w), 32'hFF);
    end

    // Reset in the 4th SHIFT cycle aborts the word.
    ctx = "mid_reset";
    bus.in_valid = 1'b1;
    bus.op_a = 8'hA5;
    bus.op_b = 8'h3C;
    @(negedge clk);
    chk("mr_ready", 32'(bus.in_ready), 1);
    tick();
    bus.in_valid = 1'b0;
    for (int j = 0; j < 4; j++) tick();
    reset = 1'b1;
    @(negedge clk);
    chk("mr_rst_ready", 32'(bus.in_ready), 0);
    chk("mr_rst_en", 32'(bus.add_en), 0);
    tick();
    reset = 1'b0;
    @(negedge clk);
    chk("mr_busy", 32'(bus.busy), 0);
    chk("mr_en", 32'(bus.add_en), 0);
    chk("mr_last", 32'(bus.last), 0);
    chk("mr_ready_after", 32'(bus.in_ready), 1);
    tick();
    send_word(8'h96, 8'h5A, 1'b0, 32'h0, 1'b0, 8'h5A, 8'hF0, 8);

    // Random words against the arithmetic model.
    for (int i = 0; i < 40; i++) begin
      ra = W'($urandom);
      rb = W'($urandom);
`ifdef SERIAL_OPERAND_SUB_EN
      rsub = 1'($urandom_range(0, 1));
`else
      rsub = 1'b0;
`endif
      reb = rsub ? W'(0 - int'(rb)) : rb;
      send_word(ra, rb, rsub, 32'h0, 1'b1, reb, W'(ra + reb), -1);
      for (int g = $urandom_range(0, 2); g > 0; g--) begin
        bus.in_valid = 1'b0;
        @(negedge clk);
        chk("gap_ready", 32'(bus.in_ready), 1);
        tick();
      end
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
